washing_machine_load_size_detection: RTL and testbench

- Maps the measured drum load weight to a target water fill level for the washing-machine controller.
- Purely a registered classifier: 8-bit weight in, 10-bit water-level command out, updated every clock.
- Sits between the load-cell front end and the fill-valve / water-level controller.

---
 rtl/washing_machine_load_size_detection_pkg.sv | 51 +++++
 rtl/washing_machine_load_size_detection_if.sv | 11 +
 rtl/washing_machine_load_size_detection_load_class_decoder.sv | 37 +++
 rtl/washing_machine_load_size_detection.sv | 66 ++++++
 tb/tb_washing_machine_load_size_detection.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/washing_machine_load_size_detection_pkg.sv
// Shared definitions for the washing-machine load size detector.
// Holds the default class thresholds, the default water-level codes,
// the load-class enumeration and a helper that maps a class to its
// water-level code.
package washing_machine_pkg;

    // Default class thresholds (inclusive upper bound of each class).
    localparam int unsigned DEF_LOW_THRESHOLD    = 32'd20;
    localparam int unsigned DEF_MEDIUM_THRESHOLD = 32'd50;
    localparam int unsigned DEF_HIGH_THRESHOLD   = 32'd80;

    // Default water-level codes per class.
    localparam int unsigned DEF_LOW_LEVEL        = 32'd250;
    localparam int unsigned DEF_MEDIUM_LEVEL     = 32'd500;
    localparam int unsigned DEF_HIGH_LEVEL       = 32'd750;
    localparam int unsigned DEF_EXTRA_HIGH_LEVEL = 32'd1000;

    // Maximum code representable on the 10-bit water_level bus.
    localparam int unsigned LEVEL_MAX            = 32'd1023;
    localparam int unsigned WEIGHT_MAX           = 32'd255;

    typedef enum logic [2:0] {
        NONE       = 3'd0,
        LOW        = 3'd1,
        MEDIUM     = 3'd2,
        HIGH       = 3'd3,
        EXTRA_HIGH = 3'd4
    } load_class_t;

    // Select the water-level code for a load class; an unknown encoding
    // falls back to "no fill" so the valve is never opened by accident.
    function automatic logic [9:0] level_for_class(
        input load_class_t cls,
        input logic [9:0]  low_level,
        input logic [9:0]  medium_level,
        input logic [9:0]  high_level,
        input logic [9:0]  extra_high_level
    );
        logic [9:0] level;
        case (cls)
            NONE:       level = 10'd0;
            LOW:        level = low_level;
            MEDIUM:     level = medium_level;
            HIGH:       level = high_level;
            EXTRA_HIGH: level = extra_high_level;
            default:    level = 10'd0;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/washing_machine_load_size_detection_if.sv
// Bus between the load-cell front end and the fill-level controller.
//   load_weight : 8-bit unsigned measured load weight
//   water_level : 10-bit unsigned target water level
// master = load-cell side (drives weight), slave = detector (drives level).
interface washing_machine_load_size_detection_if;
    logic [7:0] load_weight;
    logic [9:0] water_level;

    modport master (output load_weight, input water_level);
    modport slave  (input load_weight, output water_level);
endinterface

// File: rtl/washing_machine_load_size_detection_load_class_decoder.sv
// Combinational weight-to-class comparator.
// Ports:
//   load_weight : 8-bit unsigned weight
//   load_class  : resulting load class (NONE for zero weight)
// A weight equal to a threshold belongs to the lower class.
module load_class_decoder
    import washing_machine_pkg::*;
#(
    parameter logic [7:0] LOW_THRESHOLD    = 8'd20,
    parameter logic [7:0] MEDIUM_THRESHOLD = 8'd50,
    parameter logic [7:0] HIGH_THRESHOLD   = 8'd80
) (
    input  logic [7:0]  load_weight,
    output load_class_t load_class
);

    load_class_t class_s;

    // Unsigned threshold compare chain, lowest class first.
    always_comb begin
        class_s = NONE;
        if (load_weight == 8'd0) begin
            class_s = NONE;
        end else if (load_weight <= LOW_THRESHOLD) begin
            class_s = LOW;
        end else if (load_weight <= MEDIUM_THRESHOLD) begin
            class_s = MEDIUM;
        end else if (load_weight <= HIGH_THRESHOLD) begin
            class_s = HIGH;
        end else begin
            class_s = EXTRA_HIGH;
        end
    end

    assign load_class = class_s;

endmodule

// File: rtl/washing_machine_load_size_detection.sv
// Washing-machine load size detector: classifies the drum load weight and
// registers the matching target water level, one cycle after sampling.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset; clears water_level to 0
//   bus   : slave side of the weight/level bus
//           (load_weight in, water_level out, registered)
module washing_machine_load_size_detection
    import washing_machine_pkg::*;
#(
    parameter int unsigned LOW_THRESHOLD    = DEF_LOW_THRESHOLD,
    parameter int unsigned MEDIUM_THRESHOLD = DEF_MEDIUM_THRESHOLD,
    parameter int unsigned HIGH_THRESHOLD   = DEF_HIGH_THRESHOLD,
    parameter int unsigned LOW_LEVEL        = DEF_LOW_LEVEL,
    parameter int unsigned MEDIUM_LEVEL     = DEF_MEDIUM_LEVEL,
    parameter int unsigned HIGH_LEVEL       = DEF_HIGH_LEVEL,
    parameter int unsigned EXTRA_HIGH_LEVEL = DEF_EXTRA_HIGH_LEVEL
) (
    input  logic clk,
    input  logic reset,
    washing_machine_load_size_detection_if.slave bus
);

    // Reject parameter sets that cannot be represented or ordered.
    if (HIGH_THRESHOLD > WEIGHT_MAX) begin : g_bad_threshold_width
        $error("thresholds must fit in 8 bits");
    end
    if (!((LOW_THRESHOLD < MEDIUM_THRESHOLD) && (MEDIUM_THRESHOLD < HIGH_THRESHOLD))) begin : g_bad_threshold_order
        $error("thresholds must be strictly increasing");
    end
    if ((LOW_LEVEL > LEVEL_MAX) || (MEDIUM_LEVEL > LEVEL_MAX) ||
        (HIGH_LEVEL > LEVEL_MAX) || (EXTRA_HIGH_LEVEL > LEVEL_MAX)) begin : g_bad_level_width
        $error("water levels must fit in 10 bits");
    end

    load_class_t class_s;
    logic [9:0]  level_s;
    logic [9:0]  level_r;

    load_class_decoder #(
        .LOW_THRESHOLD    (8'(LOW_THRESHOLD)),
        .MEDIUM_THRESHOLD (8'(MEDIUM_THRESHOLD)),
        .HIGH_THRESHOLD   (8'(HIGH_THRESHOLD))
    ) u_decoder (
        .load_weight (bus.load_weight),
        .load_class  (class_s)
    );

    assign level_s = level_for_class(class_s,
                                     10'(LOW_LEVEL),
                                     10'(MEDIUM_LEVEL),
                                     10'(HIGH_LEVEL),
                                     10'(EXTRA_HIGH_LEVEL));

    // Output register: the only path from weight to level goes through here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_r <= 10'd0;
        end else begin
            level_r <= level_s;
        end
    end

    assign bus.water_level = level_r;

endmodule

// File: tb/tb_washing_machine_load_size_detection.sv
// Scoreboard bench for the load size detector: stimulus pushes the expected
// level for each sampling edge, a monitor pops and compares just after it.
module tb_washing_machine_load_size_detection;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    typedef struct {
        logic [9:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    washing_machine_load_size_detection_if bus ();

    washing_machine_load_size_detection dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: hard-coded class table.
    function automatic logic [9:0] ref_level(input logic [7:0] w);
        if (w == 8'd0)        return 10'd0;
        else if (w <= 8'd20)  return 10'd250;
        else if (w <= 8'd50)  return 10'd500;
        else if (w <= 8'd80)  return 10'd750;
        else                  return 10'd1000;
    endfunction

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: water_level=%0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive a new weight away from the active edge and expect its level
    // after the next rising edge.
    task automatic apply(input logic [7:0] w, input logic [9:0] e, input string nm);
        exp_t item;
        @(negedge clk);
        bus.load_weight = w;
        item.exp  = e;
        item.name = nm;
        exp_q.push_back(item);
    endtask

    // Keep the current weight for one more edge, expecting the same level.
    task automatic hold(input logic [9:0] e, input string nm);
        exp_t item;
        @(negedge clk);
        item.exp  = e;
        item.name = nm;
        exp_q.push_back(item);
    endtask

    // Monitor: after each rising edge compare against the scoreboard head,
    // and confirm only legal level codes appear while out of reset.
    always @(posedge clk) begin
        exp_t item;
        logic [9:0] lvl;
        #1;
        lvl = bus.water_level;
        if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            check(item.name, lvl, item.exp);
        end
        if (reset === 1'b1) begin
            tests_run++;
            if (!(lvl === 10'd0 || lvl === 10'd250 || lvl === 10'd500 ||
                  lvl === 10'd750 || lvl === 10'd1000)) begin
                tests_failed++;
                $display("FAIL legal_code: water_level=%0d, expected one of 0/250/500/750/1000", lvl);
            end
        end
    end

    initial begin
        logic [7:0] w;
        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b0;
        bus.load_weight = 8'd0;

        // Reset held for two cycles.
        #1;
        check("reset_initial", bus.water_level, 10'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_held", bus.water_level, 10'd0);
        reset = 1'b1;

        // Class interiors.
        apply(8'd10, 10'd250,  "interior_10");
        apply(8'd30, 10'd500,  "interior_30");
        apply(8'd60, 10'd750,  "interior_60");
        apply(8'd90, 10'd1000, "interior_90");

        // Exact boundaries.
        apply(8'd20,  10'd250,  "bound_20");
        apply(8'd21,  10'd500,  "bound_21");
        apply(8'd50,  10'd500,  "bound_50");
        apply(8'd51,  10'd750,  "bound_51");
        apply(8'd80,  10'd750,  "bound_80");
        apply(8'd81,  10'd1000, "bound_81");
        apply(8'd0,   10'd0,    "bound_0");
        apply(8'd1,   10'd250,  "bound_1");
        apply(8'd255, 10'd1000, "bound_255");

        // Latency: change just after an edge, output must wait one edge.
        apply(8'd10, 10'd250, "lat_pre");
        @(posedge clk);
        #2;
        bus.load_weight = 8'd90;
        #1;
        check("lat_hold_after_change", bus.water_level, 10'd250);
        hold(10'd1000, "lat_next_edge");
        check("lat_hold_negedge", bus.water_level, 10'd250);

        // Asynchronous reset in the middle of operation.
        apply(8'd90, 10'd1000, "pre_reset_90");
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", bus.water_level, 10'd0);
        @(negedge clk);
        check("async_reset_held", bus.water_level, 10'd0);
        reset = 1'b1;
        apply(8'd90, 10'd1000, "post_reset_90");

        // Random weights, each held two cycles.
        for (int i = 0; i < 32; i++) begin
            w = 8'($urandom_range(1, 255));
            apply(w, ref_level(w), "random");
            hold(ref_level(w), "random_hold");
        end

        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
